mnist_dlayer2_argmax: RTL and testbench
=======================================

MNIST_DLAYER2_ARGMAX -- requirements
Module: mnist_dlayer2_argmax

Interface
REQ-001 SHALL have parameter: N_CLASSES, 10, scores per image (2..16).
REQ-002 SHALL have parameter: CW, 4, class-index width; CW SHALL be at least ceil(log2(N_CLASSES)).
REQ-003 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_valid  in  1  in_score valid this cycle.
REQ-006 SHALL have port: in_score  in  32  IEEE-754 single-precision class score (dense-layer-2 node output c).
REQ-007 SHALL have port: in_ready  out  1  block can accept a score.
REQ-008 SHALL have port: out_valid  out  1  result available.
REQ-009 SHALL have port: out_ready  in  1  consumer takes result.
REQ-010 SHALL have port: out_class  out  CW  index of maximum score.
REQ-011 SHALL have port: out_score  out  32  maximum score (raw bits).

Function
REQ-012 SHALL accept a score only on a cycle with in_valid=1 and in_ready=1 (a transfer).
REQ-013 SHALL implement two states: ACC (collecting) and HOLD (result pending).
REQ-014 ACC: in_ready=1 and out_valid=0.
REQ-015 HOLD: in_ready=0 and out_valid=1.
REQ-016 SHALL keep a score counter cnt, 0..N_CLASSES-1; cnt SHALL increment on each transfer, and the transfer's index SHALL be the cnt value before the increment.
REQ-017 On transfer at cnt=0: SHALL load max_score=in_score and max_idx=0 unconditionally.
REQ-018 On transfer at cnt>0: SHALL replace max_score/max_idx with in_score/cnt only if in_score is strictly greater under REQ-019..021.
REQ-019 Ordering: SHALL use the key = (bit31 ? ~bits : bits ^ 32'h8000_0000) compared as unsigned; +0 therefore ranks above -0.
REQ-020 Ties (equal keys): the earlier index SHALL be kept.
REQ-021 NaN (exp=8'hFF, mantissa!=0) SHALL never replace the current max; any non-NaN SHALL replace a NaN current max; Inf SHALL compare by the key.
REQ-022 On transfer at cnt=N_CLASSES-1: SHALL apply the compare, wrap cnt to 0, and enter HOLD on the next edge.
REQ-023 out_valid SHALL rise on the cycle after the last transfer (latency 1).
REQ-024 out_class/out_score SHALL be registered, taken from max_idx/max_score, and stable while out_valid=1.
REQ-025 In HOLD with out_ready=1: SHALL return to ACC on the next edge, with out_valid=0 that cycle.
REQ-026 In HOLD with out_ready=0: SHALL stay in HOLD indefinitely and hold the result.
REQ-027 SHALL ignore in_valid while in HOLD; no state change and no score consumed.
REQ-028 in_valid gaps within an image SHALL not affect the result; cnt SHALL hold between transfers.
REQ-029 Throughput SHALL be one image per N_CLASSES+1 cycles minimum when out_ready is held at 1.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=ACC, cnt=0, max_score=0, max_idx=0, out_valid=0, out_class=0, out_score=0.
REQ-031 Reset mid-image or in HOLD SHALL discard the partial image or result.
REQ-032 The first transfer after reset release SHALL be index 0.
REQ-033 in_ready SHALL be 1 during and immediately after reset.

Verification
REQ-034 Ten scores, 0x3F800000 ×9 with 0x40000000 at index 6, out_ready=1 -> out_valid pulses 1 cycle after the 10th transfer with out_class=6 and out_score=0x40000000.
REQ-035 All scores 0xBF800000 except index 3=0xC0000000 and index 8=0xBF800000 -> out_class=0 (tie, earliest kept).
REQ-036 Index 0=0x80000000 (-0) and index 5=0x00000000 (+0), all others 0xC0000000 -> out_class=5.
REQ-037 Index 0=0x7FC00000 (NaN), index 2=0xFF800000 (-Inf), others NaN -> out_class=2.
REQ-038 out_ready=0 for 5 cycles after result, with in_valid=1 driven throughout -> in_ready=0 and outputs stable; after out_ready=1, the next transfer is indexed 0 of the new image.
REQ-039 rst_n asserted after 4 transfers, then 10 fresh scores -> result reflects only the post-reset image.

Source files
------------

// File: rtl/mnist_dlayer2_argmax.sv
// Streaming argmax over the N_CLASSES float32 scores of dense layer 2.
// Collects one image's scores, then holds {class, score} until the consumer takes it.
module mnist_dlayer2_argmax #(
  parameter int N_CLASSES = 10,
  parameter int CW        = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [31:0]   in_score,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_class,
  output logic [31:0]   out_score
);

  typedef enum logic {ACC, HOLD} state_t;

  localparam logic [CW-1:0] LAST_IDX = CW'(N_CLASSES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] max_idx;
  logic [31:0]   max_score;

  logic          xfer;
  logic          take;
  logic [CW-1:0] nxt_idx;
  logic [31:0]   nxt_score;

  // Maps float bits onto an unsigned total order: negatives reversed below
  // positives, so -0 sits just under +0.
  function automatic logic [31:0] order_key(input logic [31:0] b);
    return b[31] ? ~b : (b ^ 32'h8000_0000);
  endfunction

  function automatic logic is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  assign in_ready = (state == ACC);
  assign xfer     = in_valid && in_ready;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    take = 1'b0;
    if (cnt == '0)
      take = 1'b1;
    else if (is_nan(in_score))
      take = 1'b0;
    else if (is_nan(max_score))
      take = 1'b1;
    else
      take = order_key(in_score) > order_key(max_score);
  end

  // Strict greater-than above keeps the earlier index on ties.
  assign nxt_score = take ? in_score : max_score;
  assign nxt_idx   = take ? cnt      : max_idx;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      cnt       <= '0;
      max_idx   <= '0;
      max_score <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_score <= '0;
    end else begin
      case (state)
        ACC: begin
          if (xfer) begin
            max_score <= nxt_score;
            max_idx   <= nxt_idx;
            if (cnt == LAST_IDX) begin
              // Result registers load the post-compare max on the same edge.
              cnt       <= '0;
              state     <= HOLD;
              out_valid <= 1'b1;
              out_class <= nxt_idx;
              out_score <= nxt_score;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_dlayer2_argmax.sv
// Directed bench for mnist_dlayer2_argmax: a table of ten-score images with
// hand-computed winners, plus back-pressure and reset sequences.
module tb_mnist_dlayer2_argmax;

  localparam int N  = 10;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [31:0]   in_score;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_class;
  logic [31:0]   out_score;

  mnist_dlayer2_argmax #(.N_CLASSES(N), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_score  (in_score),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][31:0] s;
    logic [CW-1:0]      cls;
    logic [31:0]        score;
    logic               gaps;
  } vec_t;

  vec_t vecs [7];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_score(input logic [31:0] s);
    in_valid = 1'b1;
    in_score = s;
    check("in_ready_acc", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic rdy, input string name);
    out_ready = rdy;
    for (int i = 0; i < N; i++) begin
      if (v.gaps && i > 0) begin
        tick();
        tick();
        check({name, "_gap_ready"}, 32'(in_ready), 32'd1);
      end
      send_score(v.s[i]);
    end
    check({name, "_latency"}, 32'(out_valid), 32'd1);
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    check({name, "_class"}, 32'(out_class), 32'(v.cls));
    check({name, "_score"}, out_score, v.score);
    check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
    if (rdy) begin
      tick();
      check({name, "_drop"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1.0 everywhere, 2.0 at index 6.
    for (int i = 0; i < N; i++) vecs[0].s[i] = 32'h3F80_0000;
    vecs[0].s[6] = 32'h4000_0000; vecs[0].cls = 4'd6; vecs[0].score = 32'h4000_0000; vecs[0].gaps = 1'b0;
    // -1.0 everywhere, -2.0 at 3: tie at -1.0 keeps index 0.
    for (int i = 0; i < N; i++) vecs[1].s[i] = 32'hBF80_0000;
    vecs[1].s[3] = 32'hC000_0000; vecs[1].cls = 4'd0; vecs[1].score = 32'hBF80_0000; vecs[1].gaps = 1'b0;
    // -0 at 0, +0 at 5, -2.0 elsewhere: +0 ranks above -0.
    for (int i = 0; i < N; i++) vecs[2].s[i] = 32'hC000_0000;
    vecs[2].s[0] = 32'h8000_0000; vecs[2].s[5] = 32'h0000_0000;
    vecs[2].cls = 4'd5; vecs[2].score = 32'h0000_0000; vecs[2].gaps = 1'b0;
    // NaN everywhere except -Inf at 2: any non-NaN replaces a NaN max.
    for (int i = 0; i < N; i++) vecs[3].s[i] = 32'h7FC0_0000;
    vecs[3].s[2] = 32'hFF80_0000; vecs[3].cls = 4'd2; vecs[3].score = 32'hFF80_0000; vecs[3].gaps = 1'b0;
    // +Inf at the last index, with idle gaps between transfers.
    for (int i = 0; i < N; i++) vecs[4].s[i] = 32'h3F80_0000;
    vecs[4].s[9] = 32'h7F80_0000; vecs[4].cls = 4'd9; vecs[4].score = 32'h7F80_0000; vecs[4].gaps = 1'b1;
    // All NaN: index 0 loads unconditionally and is never replaced.
    for (int i = 0; i < N; i++) vecs[5].s[i] = 32'h7FC0_0000;
    vecs[5].s[0] = 32'hFFC0_0000; vecs[5].cls = 4'd0; vecs[5].score = 32'hFFC0_0000; vecs[5].gaps = 1'b0;
    // Negatives with a NaN in between: -1.0 at 2 wins over -3.0 and -2.0.
    for (int i = 0; i < N; i++) vecs[6].s[i] = 32'hC000_0000;
    vecs[6].s[0] = 32'hC040_0000; vecs[6].s[1] = 32'h7FC0_0000; vecs[6].s[2] = 32'hBF80_0000;
    vecs[6].cls = 4'd2; vecs[6].score = 32'hBF80_0000; vecs[6].gaps = 1'b0;

    rst_n = 1'b0; in_valid = 1'b0; in_score = '0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_out_score", out_score, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 7; v++) run_vec(vecs[v], 1'b1, $sformatf("vec%0d", v));

    // Back-pressure: result held while in_valid is driven with +Inf.
    run_vec(vecs[1], 1'b0, "bp");
    in_valid = 1'b1;
    in_score = 32'h7F80_0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_class", 32'(out_class), 32'd0);
      check("bp_score", out_score, 32'hBF80_0000);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_release", 32'(out_valid), 32'd0);
    run_vec(vecs[0], 1'b1, "bp_next");

    // Reset after four +Inf transfers discards the partial image.
    for (int i = 0; i < 4; i++) send_score(32'h7F80_0000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    run_vec(vecs[0], 1'b1, "after_mid_rst");

    // Reset while holding a result discards it.
    run_vec(vecs[2], 1'b0, "hold_pre");
    rst_n = 1'b0;
    #1;
    check("hold_rst_out_valid", 32'(out_valid), 32'd0);
    check("hold_rst_out_class", 32'(out_class), 32'd0);
    check("hold_rst_out_score", out_score, 32'd0);
    check("hold_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    run_vec(vecs[3], 1'b1, "after_hold_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
